if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 111 +++++++++++
 tb/tb_if_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding request to instruction memory, a
// registered output to decode, and a one-entry holding buffer for words that
// return while decode is stalled.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_req;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic [XLEN-1:0] r_buf;
  logic [XLEN-1:0] r_buf_pc;

  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_next_pc;
  logic            w_accept;

  assign w_redirect_pc = redirect_pc_i & ~XLEN'(3);
  assign w_next_pc     = r_fetch_pc + PC_STEP;
  // r_req is low in the cycle right after reset, so no request can complete then
  assign w_accept      = r_req && mem_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_req      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_valid    <= 1'b0;
      r_buf      <= '0;
      r_buf_pc   <= '0;
    end else if (redirect_i) begin
      r_state    <= S_FETCH;
      r_req      <= 1'b1;
      r_fetch_pc <= w_redirect_pc;
      r_instr    <= NOP_INSTR;
      r_valid    <= 1'b0;
      r_buf      <= '0;
      r_buf_pc   <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_req <= 1'b1;
          if (w_accept) begin
            r_fetch_pc <= w_next_pc;
            if (r_valid && stall_i) begin
              r_buf    <= mem_rdata_i;
              r_buf_pc <= r_fetch_pc;
              r_req    <= 1'b0;
              r_state  <= S_HOLD;
            end else begin
              r_instr <= mem_rdata_i;
              r_pc    <= r_fetch_pc;
              r_valid <= 1'b1;
            end
          end else if (!stall_i) begin
            // nothing arrived and decode took the old word: insert a bubble
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            r_instr <= r_buf;
            r_pc    <= r_buf_pc;
            r_valid <= 1'b1;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end
      endcase
    end
  end

  assign mem_req_o  = r_req;
  assign mem_addr_o = r_fetch_pc;
  assign instr_o    = r_instr;
  assign pc_o       = r_pc;
  assign valid_o    = r_valid;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenario tasks plus a scoreboard that records
// every completed fetch and checks it appears on the decode side in order.
module tb_if_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] sb_q[$];
  logic [31:0] exp_fetch_pc;

  if_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ready_i  (mem_ready_i),
    .mem_rdata_i  (mem_rdata_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .valid_o      (valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'(a * 32'd7) ^ 32'h1357_9BDF;
  endfunction

  // Memory model: returns a word derived from the requested address
  always_comb mem_rdata_i = mem_ready_i ? mem_word(mem_addr_o) : 32'hDEAD_BEEF;

  // Scoreboard monitor, sampled on the falling edge when all signals are stable
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_fetch_pc = RESET_PC;
    end else begin
      n_cmp++;
      if (mem_addr_o !== exp_fetch_pc) begin
        n_err++;
        $display("FAIL sb_addr: mem_addr_o=%h expected %h", mem_addr_o, exp_fetch_pc);
      end
      if (valid_o && !stall_i) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_extra: pc_o=%h instr_o=%h delivered with nothing outstanding", pc_o, instr_o);
        end else begin
          logic [63:0] e;
          e = sb_q.pop_front();
          if ({pc_o, instr_o} !== e) begin
            n_err++;
            $display("FAIL sb_order: pc/instr=%h/%h expected %h/%h", pc_o, instr_o, e[63:32], e[31:0]);
          end
        end
      end
      if (redirect_i) begin
        sb_q.delete();
        exp_fetch_pc = redirect_pc_i & ~32'h3;
      end else if (mem_req_o && mem_ready_i) begin
        sb_q.push_back({exp_fetch_pc, mem_word(exp_fetch_pc)});
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic rdy, input logic rd, input logic [31:0] rpc);
    stall_i       = st;
    mem_ready_i   = rdy;
    redirect_i    = rd;
    redirect_pc_i = rpc;
  endtask

  // Reset, then leave the stage in its first requesting cycle at RESET_PC
  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    step();
    n_cmp++;
    if ({mem_req_o, valid_o, instr_o, pc_o} !== {1'b0, 1'b0, NOP_INSTR, 32'h0}) begin
      n_err++;
      $display("FAIL reset_state: req=%b valid=%b instr=%h pc=%h expected 0 0 %h 0",
               mem_req_o, valid_o, instr_o, pc_o, NOP_INSTR);
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    n_cmp++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, RESET_PC}) begin
      n_err++;
      $display("FAIL reset_first_req: req=%b addr=%h expected 1 %h", mem_req_o, mem_addr_o, RESET_PC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if ({valid_o, pc_o, mem_addr_o} !== {1'b1, 32'(4 * i), 32'(4 * i + 4)}) begin
        n_err++;
        $display("FAIL stream_%0d: valid=%b pc=%h addr=%h expected 1 %h %h",
                 i, valid_o, pc_o, mem_addr_o, 32'(4 * i), 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_bubble();
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({mem_req_o, mem_addr_o, valid_o, instr_o} !== {1'b1, 32'h8, 1'b0, NOP_INSTR}) begin
        n_err++;
        $display("FAIL bubble_%0d: req=%b addr=%h valid=%b instr=%h expected 1 8 0 %h",
                 i, mem_req_o, mem_addr_o, valid_o, instr_o, NOP_INSTR);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    n_cmp++;
    if ({valid_o, pc_o, instr_o} !== {1'b1, 32'h8, mem_word(32'h8)}) begin
      n_err++;
      $display("FAIL bubble_resume: valid=%b pc=%h instr=%h expected 1 8 %h",
               valid_o, pc_o, instr_o, mem_word(32'h8));
    end
  endtask

  // Leaves the stage in HOLD with pc_o=4 on the output and word@8 buffered
  task automatic enter_hold();
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
  endtask

  task automatic test_hold();
    enter_hold();
    n_cmp++;
    if ({mem_req_o, valid_o, pc_o} !== {1'b0, 1'b1, 32'h4}) begin
      n_err++;
      $display("FAIL hold_enter: req=%b valid=%b pc=%h expected 0 1 4", mem_req_o, valid_o, pc_o);
    end
    step();
    n_cmp++;
    if ({mem_req_o, pc_o, mem_addr_o} !== {1'b0, 32'h4, 32'hC}) begin
      n_err++;
      $display("FAIL hold_keep: req=%b pc=%h addr=%h expected 0 4 c", mem_req_o, pc_o, mem_addr_o);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    n_cmp++;
    if ({valid_o, pc_o, instr_o, mem_req_o, mem_addr_o} !==
        {1'b1, 32'h8, mem_word(32'h8), 1'b1, 32'hC}) begin
      n_err++;
      $display("FAIL hold_release: valid=%b pc=%h instr=%h req=%b addr=%h expected 1 8 %h 1 c",
               valid_o, pc_o, instr_o, mem_req_o, mem_addr_o, mem_word(32'h8));
    end
    step();
    n_cmp++;
    if (pc_o !== 32'hC) begin
      n_err++;
      $display("FAIL hold_next: pc=%h expected c", pc_o);
    end
  endtask

  task automatic test_redirect();
    enter_hold();
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    step();
    n_cmp++;
    if ({valid_o, instr_o, mem_req_o, mem_addr_o} !== {1'b0, NOP_INSTR, 1'b1, 32'h100}) begin
      n_err++;
      $display("FAIL redirect_flush: valid=%b instr=%h req=%b addr=%h expected 0 %h 1 100",
               valid_o, instr_o, mem_req_o, mem_addr_o, NOP_INSTR);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    n_cmp++;
    if ({valid_o, pc_o, instr_o} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
      n_err++;
      $display("FAIL redirect_target: valid=%b pc=%h instr=%h expected 1 100 %h",
               valid_o, pc_o, instr_o, mem_word(32'h100));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    n_cmp++;
    if ({pc_o, mem_addr_o} !== {32'hFFFF_FFFC, 32'h0}) begin
      n_err++;
      $display("FAIL wrap: pc=%h addr=%h expected fffffffc 0", pc_o, mem_addr_o);
    end
    step();
    n_cmp++;
    if ({valid_o, pc_o} !== {1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL wrap_next: valid=%b pc=%h expected 1 0", valid_o, pc_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0040);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({valid_o, mem_req_o, mem_addr_o} !== {1'b0, 1'b0, RESET_PC}) begin
      n_err++;
      $display("FAIL reset_mid: valid=%b req=%b addr=%h expected 0 0 %h",
               valid_o, mem_req_o, mem_addr_o, RESET_PC);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({valid_o, mem_req_o, mem_addr_o} !== {1'b0, 1'b1, RESET_PC}) begin
      n_err++;
      $display("FAIL reset_mid_req: valid=%b req=%b addr=%h expected 0 1 %h",
               valid_o, mem_req_o, mem_addr_o, RESET_PC);
    end
    step();
    n_cmp++;
    if ({valid_o, pc_o} !== {1'b1, RESET_PC}) begin
      n_err++;
      $display("FAIL reset_mid_first: valid=%b pc=%h expected 1 %h", valid_o, pc_o, RESET_PC);
    end
  endtask

  // Random stall/ready/redirect traffic; ordering is checked by the scoreboard
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 70),
            1'($urandom_range(0, 99) < 4), $urandom & 32'h0000_0FFF);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_stream();
    test_bubble();
    test_hold();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
